prio_enc_seg_reg: RTL and testbench

- Parametrised, registered priority encoder with hold/lock mode, detection counter and active-low seven-segment hex readout.
- Successor to the 8-input combinational encoder/display used in the switch/LED labs. Scales to N request lines and drives multiple display digits.
- Sits between board switch inputs and the seven-segment/LED outputs of the top-level board wrapper.

---
 rtl/prio_enc_seg_reg_pkg.sv | 51 +++++
 rtl/prio_enc_seg_reg_if.sv | 50 +++++
 rtl/prio_enc_seg_reg_hex7seg.sv | 22 ++
 rtl/prio_enc_seg_reg.sv | 151 +++++++++++++++
 tb/tb_prio_enc_seg_reg.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/prio_enc_seg_reg_pkg.sv
// ---------------------------------------------------------------------------
// prio_enc_seg_reg_pkg
// Shared constants and types for the registered priority encoder with
// seven-segment readout.
//   SEG_BLANK : active-low pattern with every segment off
//   HEX_SEG   : active-low {g,f,e,d,c,b,a} patterns for hex digits 0..F
//   upd_e     : which register-update rule applies on the coming edge
//   hex_to_seg: digit + blank flag -> segment pattern
// ---------------------------------------------------------------------------
package prio_enc_seg_reg_pkg;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Packed so that HEX_SEG[v] selects the pattern for digit v; the
    // concatenation therefore lists F first and 0 last.
    localparam logic [15:0][6:0] HEX_SEG = {
        7'b0001110,
        7'b0000110,
        7'b0100001,
        7'b1000110,
        7'b0000011,
        7'b0001000,
        7'b0010000,
        7'b0000000,
        7'b1111000,
        7'b0000010,
        7'b0010010,
        7'b0011001,
        7'b0110000,
        7'b0100100,
        7'b1111001,
        7'b1000000
    };

    // The four register-update rules, listed from highest to lowest
    // priority. Exactly one applies on every clock edge.
    typedef enum logic [1:0] {
        UPD_DISABLE,
        UPD_CLEAR,
        UPD_HOLD,
        UPD_TRACK
    } upd_e;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] value,
                                              input logic       blank);
        logic [6:0] seg;
        seg = blank ? SEG_BLANK : HEX_SEG[value];
        return seg;
    endfunction

endpackage

// File: rtl/prio_enc_seg_reg_if.sv
// ---------------------------------------------------------------------------
// prio_enc_seg_reg_if
// Bundles the control/request inputs and the registered/display outputs of
// prio_enc_seg_reg.
//   master : drives en, hold, clr, req; observes the outputs
//   slave  : the encoder itself
// Signals:
//   en       encoder enable
//   hold     lock mode request
//   clr      synchronous clear of counter and lock
//   req      N request lines, bit N-1 highest priority
//   idx      registered index of highest set request bit (W bits)
//   valid    registered "some request was set"
//   locked   lock mode is currently holding a value
//   cnt      saturating count of valid 0->1 transitions (CNT_W bits)
//   seg_idx  active-low hex digits of idx, digit 0 in bits [6:0]
//   seg_cnt  active-low hex digits of cnt, digit 0 in bits [6:0]
// N and CNT_W must match the parameters of the attached encoder.
// ---------------------------------------------------------------------------
interface prio_enc_seg_reg_if #(
    parameter int N     = 8,
    parameter int CNT_W = 8
);

    localparam int W  = $clog2(N);
    localparam int ND = (W + 3) / 4;
    localparam int CD = CNT_W / 4;

    logic              en;
    logic              hold;
    logic              clr;
    logic [N-1:0]      req;
    logic [W-1:0]      idx;
    logic              valid;
    logic              locked;
    logic [CNT_W-1:0]  cnt;
    logic [7*ND-1:0]   seg_idx;
    logic [7*CD-1:0]   seg_cnt;

    modport master (
        output en, hold, clr, req,
        input  idx, valid, locked, cnt, seg_idx, seg_cnt
    );

    modport slave (
        input  en, hold, clr, req,
        output idx, valid, locked, cnt, seg_idx, seg_cnt
    );

endinterface

// File: rtl/prio_enc_seg_reg_hex7seg.sv
// ---------------------------------------------------------------------------
// hex7seg
// One seven-segment hex digit decoder, active-low outputs.
// Ports:
//   value  in  4  hex digit to show
//   blank  in  1  1 = all segments off
//   seg    out 7  {g,f,e,d,c,b,a}, active-low
// ---------------------------------------------------------------------------
module hex7seg
    import prio_enc_seg_reg_pkg::*;
(
    input  logic [3:0] value,
    input  logic       blank,
    output logic [6:0] seg
);

    // Pure table lookup; blanking overrides the digit.
    always_comb begin
        seg = hex_to_seg(value, blank);
    end

endmodule

// File: rtl/prio_enc_seg_reg.sv
// ---------------------------------------------------------------------------
// prio_enc_seg_reg
// Registered N-input priority encoder with a hold/lock mode, a saturating
// detection counter and active-low hex readouts of the index and count.
// Ports:
//   clk    in  1  system clock
//   rst_n  in  1  asynchronous active-low reset
//   bus    slave modport of prio_enc_seg_reg_if (en, hold, clr, req in;
//          idx, valid, locked, cnt, seg_idx, seg_cnt out)
// Parameters:
//   N      number of request lines (2..64)
//   CNT_W  counter width (4..16, multiple of 4)
// ---------------------------------------------------------------------------
module prio_enc_seg_reg
    import prio_enc_seg_reg_pkg::*;
#(
    parameter int N     = 8,
    parameter int CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    prio_enc_seg_reg_if.slave     bus
);

    localparam int W  = $clog2(N);
    localparam int ND = (W + 3) / 4;
    localparam int CD = CNT_W / 4;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [W-1:0]     enc;
    logic             any;
    upd_e             upd;

    logic [W-1:0]     idx_q,    idx_d;
    logic             valid_q,  valid_d;
    logic             locked_q, locked_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;

    logic [4*ND-1:0]  idx_ext;
    logic [7*ND-1:0]  seg_idx_w;
    logic [7*CD-1:0]  seg_cnt_w;

    // Priority encoder: scan upward so the highest set bit is the last
    // one written. With no request set, enc stays at zero.
    always_comb begin
        enc = '0;
        any = |bus.req;
        for (int i = 0; i < N; i++) begin
            if (bus.req[i]) begin
                enc = W'(i);
            end
        end
    end

    // Pick the update rule for this edge. Disable beats clear, clear beats
    // an active lock, and everything else is normal tracking.
    always_comb begin
        upd = UPD_TRACK;
        if (!bus.en) begin
            upd = UPD_DISABLE;
        end else if (bus.clr) begin
            upd = UPD_CLEAR;
        end else if (locked_q && bus.hold) begin
            upd = UPD_HOLD;
        end
    end

    // Next-state values for the registers. The counter only advances while
    // tracking, and only on a 0->1 edge of valid, so clearing or disabling
    // can never produce a count. The lock is only taken when the captured
    // value is valid, which also covers hold rising on the same edge as
    // the first valid request.
    always_comb begin
        idx_d    = idx_q;
        valid_d  = valid_q;
        locked_d = locked_q;
        cnt_d    = cnt_q;
        case (upd)
            UPD_DISABLE: begin
                idx_d    = '0;
                valid_d  = 1'b0;
                locked_d = 1'b0;
                if (bus.clr) begin
                    cnt_d = '0;
                end
            end
            UPD_CLEAR: begin
                idx_d    = enc;
                valid_d  = any;
                locked_d = 1'b0;
                cnt_d    = '0;
            end
            UPD_HOLD: begin
            end
            default: begin
                idx_d    = enc;
                valid_d  = any;
                locked_d = bus.hold & any;
                if (!valid_q && any && (cnt_q != CNT_MAX)) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        endcase
    end

    // State registers; reset clears everything without waiting for a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q    <= '0;
            valid_q  <= 1'b0;
            locked_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            idx_q    <= idx_d;
            valid_q  <= valid_d;
            locked_q <= locked_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.idx    = idx_q;
    assign bus.valid  = valid_q;
    assign bus.locked = locked_q;
    assign bus.cnt    = cnt_q;

    // The index is zero-extended to whole hex digits before being split.
    assign idx_ext = (4*ND)'(idx_q);

    // Index digits blank whenever there is no valid capture; count digits
    // always show the count and only blank while reset is held.
    for (genvar g = 0; g < ND; g++) begin : g_seg_idx
        hex7seg u_hex (
            .value (idx_ext[4*g +: 4]),
            .blank (!valid_q),
            .seg   (seg_idx_w[7*g +: 7])
        );
    end

    for (genvar g = 0; g < CD; g++) begin : g_seg_cnt
        hex7seg u_hex (
            .value (cnt_q[4*g +: 4]),
            .blank (!rst_n),
            .seg   (seg_cnt_w[7*g +: 7])
        );
    end

    assign bus.seg_idx = seg_idx_w;
    assign bus.seg_cnt = seg_cnt_w;

endmodule

// File: tb/tb_prio_enc_seg_reg.sv
// ---------------------------------------------------------------------------
// tb_prio_enc_seg_reg
// Self-checking bench for prio_enc_seg_reg. Two instances (N=8 and N=32,
// both CNT_W=8) run side by side against a behavioural model of the
// encoder, lock and counter rules, with directed scenarios followed by
// random traffic.
// ---------------------------------------------------------------------------
module tb_prio_enc_seg_reg;

    localparam int CNT_MAX = 255;

    logic clk;
    logic rst_n;

    logic        enIn   [2];
    logic        holdIn [2];
    logic        clrIn  [2];
    logic [63:0] reqIn  [2];

    int nLines [2];
    int nDigits[2];

    int  mIdx   [2];
    bit  mValid [2];
    bit  mLocked[2];
    int  mCnt   [2];

    int checks;
    int failures;

    logic [6:0] hexTab [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    prio_enc_seg_reg_if #(.N(8),  .CNT_W(8)) if8 ();
    prio_enc_seg_reg_if #(.N(32), .CNT_W(8)) if32 ();

    assign if8.en    = enIn[0];
    assign if8.hold  = holdIn[0];
    assign if8.clr   = clrIn[0];
    assign if8.req   = reqIn[0][7:0];
    assign if32.en   = enIn[1];
    assign if32.hold = holdIn[1];
    assign if32.clr  = clrIn[1];
    assign if32.req  = reqIn[1][31:0];

    prio_enc_seg_reg #(.N(8), .CNT_W(8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if8)
    );

    prio_enc_seg_reg #(.N(32), .CNT_W(8)) dut32 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if32)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Highest set request line below n, or 0 when none is set.
    function automatic int highestSet(input logic [63:0] r, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            if (r[i]) return i;
        end
        return 0;
    endfunction

    function automatic bit anySet(input logic [63:0] r, input int n);
        for (int i = 0; i < n; i++) begin
            if (r[i]) return 1'b1;
        end
        return 1'b0;
    endfunction

    // Segment picture of a value split into hex digits, or all blank.
    function automatic logic [13:0] segPicture(input int value, input int digits,
                                               input bit blank);
        logic [13:0] pic;
        pic = '0;
        for (int k = 0; k < digits; k++) begin
            pic[7*k +: 7] = blank ? 7'b1111111 : hexTab[(value >> (4*k)) % 16];
        end
        return pic;
    endfunction

    // Clear both models, as a reset does.
    task automatic modelReset();
        for (int i = 0; i < 2; i++) begin
            mIdx[i]    = 0;
            mValid[i]  = 1'b0;
            mLocked[i] = 1'b0;
            mCnt[i]    = 0;
        end
    endtask

    // Behaviour of one clock edge, straight from the register-update rules.
    task automatic modelEdge(input int i);
        int  e;
        bit  a;
        e = highestSet(reqIn[i], nLines[i]);
        a = anySet(reqIn[i], nLines[i]);
        if (!enIn[i]) begin
            mIdx[i] = 0;
            mValid[i] = 1'b0;
            mLocked[i] = 1'b0;
            if (clrIn[i]) mCnt[i] = 0;
        end else if (clrIn[i]) begin
            mIdx[i] = e;
            mValid[i] = a;
            mLocked[i] = 1'b0;
            mCnt[i] = 0;
        end else if (mLocked[i] && holdIn[i]) begin
            mIdx[i] = mIdx[i];
        end else begin
            if (!mValid[i] && a && mCnt[i] < CNT_MAX) mCnt[i] = mCnt[i] + 1;
            mIdx[i] = e;
            mValid[i] = a;
            mLocked[i] = holdIn[i] && a;
        end
    endtask

    task automatic checkVal(input string tag, input logic [63:0] observed,
                            input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Compare every output of one instance against the model.
    task automatic checkOutput(input int i, input string tag);
        logic [63:0] oIdx, oValid, oLocked, oCnt, oSegIdx, oSegCnt;
        if (i == 0) begin
            oIdx = 64'(if8.idx);   oValid = 64'(if8.valid);
            oLocked = 64'(if8.locked); oCnt = 64'(if8.cnt);
            oSegIdx = 64'(if8.seg_idx); oSegCnt = 64'(if8.seg_cnt);
        end else begin
            oIdx = 64'(if32.idx);  oValid = 64'(if32.valid);
            oLocked = 64'(if32.locked); oCnt = 64'(if32.cnt);
            oSegIdx = 64'(if32.seg_idx); oSegCnt = 64'(if32.seg_cnt);
        end
        checkVal({tag, ".idx"},     oIdx,    64'(mIdx[i]));
        checkVal({tag, ".valid"},   oValid,  64'(mValid[i]));
        checkVal({tag, ".locked"},  oLocked, 64'(mLocked[i]));
        checkVal({tag, ".cnt"},     oCnt,    64'(mCnt[i]));
        checkVal({tag, ".seg_idx"}, oSegIdx,
                 64'(segPicture(mIdx[i], nDigits[i], !mValid[i])));
        checkVal({tag, ".seg_cnt"}, oSegCnt,
                 64'(segPicture(mCnt[i], 2, !rst_n)));
    endtask

    task automatic applyStimulus(input int i, input bit en, input bit hold,
                                 input bit clr, input logic [63:0] req);
        enIn[i]   = en;
        holdIn[i] = hold;
        clrIn[i]  = clr;
        reqIn[i]  = req;
    endtask

    // One rising edge: advance both models, then check both instances
    // shortly after the edge.
    task automatic stepCycle(input string tag);
        @(posedge clk);
        modelEdge(0);
        modelEdge(1);
        #1;
        checkOutput(0, {tag, "/n8"});
        checkOutput(1, {tag, "/n32"});
    endtask

    function automatic logic [63:0] randomReq(input int n);
        logic [63:0] r;
        case ($urandom_range(0, 3))
            0: r = '0;
            1: r = 64'd1 << $urandom_range(0, n - 1);
            2: r = {$urandom, $urandom};
            default: r = '1;
        endcase
        if (n < 64) r = r & ((64'd1 << n) - 64'd1);
        return r;
    endfunction

    initial begin
        checks   = 0;
        failures = 0;
        nLines[0] = 8;  nDigits[0] = 1;
        nLines[1] = 32; nDigits[1] = 2;
        rst_n = 1'b0;
        applyStimulus(0, 1'b1, 1'b0, 1'b0, 64'h0);
        applyStimulus(1, 1'b1, 1'b0, 1'b0, 64'h0);
        modelReset();

        // Held in reset: everything clear, all digits blank.
        repeat (2) @(posedge clk);
        #1;
        checkOutput(0, "reset/n8");
        checkOutput(1, "reset/n32");
        @(negedge clk);
        rst_n = 1'b1;
        stepCycle("release");

        // Encode several patterns; count rises only on the first valid.
        $display("[TB] directed encode and lock");
        applyStimulus(0, 1'b1, 1'b0, 1'b0, 64'h2C);
        stepCycle("req2c");
        applyStimulus(0, 1'b1, 1'b0, 1'b0, 64'h80);
        stepCycle("req80");

        // Lock on 0x04, ignore 0xFF, then release the lock.
        applyStimulus(0, 1'b1, 1'b1, 1'b0, 64'h04);
        stepCycle("lock04");
        applyStimulus(0, 1'b1, 1'b1, 1'b0, 64'hFF);
        repeat (5) stepCycle("lockedff");
        applyStimulus(0, 1'b1, 1'b0, 1'b0, 64'hFF);
        stepCycle("unlock");

        // Saturate the counter, then clear it.
        $display("[TB] counter saturation");
        for (int t = 0; t < 300; t++) begin
            applyStimulus(0, 1'b1, 1'b0, 1'b0, 64'h00);
            stepCycle("toggle0");
            applyStimulus(0, 1'b1, 1'b0, 1'b0, 64'h01);
            stepCycle("toggle1");
        end
        applyStimulus(0, 1'b1, 1'b0, 1'b1, 64'h01);
        stepCycle("clr");
        applyStimulus(0, 1'b1, 1'b0, 1'b0, 64'h01);
        stepCycle("afterclr");

        // Wide instance: top line, then disable.
        $display("[TB] wide instance");
        applyStimulus(1, 1'b1, 1'b0, 1'b0, 64'h8000_0000);
        stepCycle("top31");
        applyStimulus(1, 1'b0, 1'b0, 1'b0, 64'h8000_0000);
        stepCycle("disable");
        applyStimulus(1, 1'b1, 1'b1, 1'b0, 64'h0001_0000);
        stepCycle("holdfirst");

        // Random traffic on both instances.
        $display("[TB] random traffic");
        for (int t = 0; t < 400; t++) begin
            for (int i = 0; i < 2; i++) begin
                applyStimulus(i, ($urandom_range(0, 9) != 0),
                              ($urandom_range(0, 1) == 1),
                              ($urandom_range(0, 15) == 0),
                              randomReq(nLines[i]));
            end
            stepCycle("random");
        end

        // Build cnt=3 with a lock held, then reset mid-cycle.
        $display("[TB] reset while locked");
        applyStimulus(0, 1'b1, 1'b0, 1'b1, 64'h00);
        applyStimulus(1, 1'b1, 1'b0, 1'b0, 64'h00);
        stepCycle("preclr");
        for (int t = 0; t < 2; t++) begin
            applyStimulus(0, 1'b1, 1'b0, 1'b0, 64'h10);
            stepCycle("pre1");
            applyStimulus(0, 1'b1, 1'b0, 1'b0, 64'h00);
            stepCycle("pre0");
        end
        applyStimulus(0, 1'b1, 1'b1, 1'b0, 64'h10);
        stepCycle("prelock");
        #3;
        rst_n = 1'b0;
        modelReset();
        #1;
        checkOutput(0, "asyncrst/n8");
        checkOutput(1, "asyncrst/n32");
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(0, 1'b1, 1'b0, 1'b0, 64'h02);
        stepCycle("postrst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
